cam_capture_565: RTL
====================

Name: cam_capture_565

Overview:
- Camera-side capture stage. It sits directly upstream of the 320x240 RGB565 frame buffer that the 2x-upscaling VGA scan-out reads.
- Samples the sensor's 8-bit DVP byte stream (VSYNC/HREF/D) on the sensor pixel clock and pairs bytes into RGB565 words.
- Drives the frame-buffer write port (address, data, write enable) in the row-major layout addr = y*IMG_WIDTH + x.
- Reports frame completion and framing errors to control logic.

Parameters:
- IMG_WIDTH, 320, pixels per line written to the buffer.
- IMG_HEIGHT, 240, lines per frame.
- ADDR_W, 17, write-address width. Must hold IMG_WIDTH*IMG_HEIGHT-1 (76799).

Ports:
- PCLK  in  1  sensor pixel clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  capture enable; sampled only at frame boundaries.
- vsync  in  1  sensor VSYNC; high = vertical blanking.
- href  in  1  sensor HREF; high = valid bytes on d.
- d  in  8  sensor data byte.
- wr_addr  out  ADDR_W  frame-buffer write address.
- wr_data  out  16  RGB565 word {first byte, second byte}.
- wr_en  out  1  frame-buffer write strobe, one PCLK cycle per pixel.
- frame_done  out  1  one-cycle pulse: clean frame fully written.
- frame_err  out  1  one-cycle pulse: frame ended with a framing error.
- busy  out  1  high while in CAPTURE.

Behaviour:
- Reset: state IDLE; wr_addr=0, wr_data=0, wr_en=0, frame_done=0, frame_err=0, busy=0. Byte-phase, error flag and line counter are cleared. Reset mid-frame aborts the frame with no pulse; capture resumes only after a fresh vsync high->low edge.
- Input stage: vsync, href and d are registered once every PCLK (s1). All decisions use s1 values plus one delayed vsync/href copy for edge detection.
- FSM:
  - IDLE: if enable=1 and s1 vsync=1, go to ARMED.
  - ARMED: on s1 vsync falling edge, go to CAPTURE. Clear wr_addr, pixel-in-line counter, byte phase and err flag. If enable drops while ARMED, return to IDLE.
  - CAPTURE: busy=1. On s1 vsync rising edge (frame end), issue exactly one of frame_done or frame_err in the next cycle. Then go to ARMED if enable=1, else IDLE. enable low mid-frame does not abort; the frame completes.
- Byte pairing, while in CAPTURE with s1 href=1:
  - phase 0 latches the high byte.
  - phase 1 forms wr_data={hi, lo}.
  - Latency: the second byte present on d at edge n gives wr_en=1 with valid wr_data/wr_addr in the cycle after edge n+1, i.e. 2 PCLK.
- Address: wr_addr holds its value during the write cycle and increments by 1 in the cycle after each write. Writes attempted when wr_addr would exceed IMG_WIDTH*IMG_HEIGHT-1 are suppressed (wr_en stays 0) and set err.
- Line check, on s1 href falling edge:
  - A pixel count != IMG_WIDTH sets err.
  - Odd leftover phase (dangling high byte) sets err; the byte is discarded.
  - Phase and pixel counter reset at every href fall.
- Frame end:
  - frame_done=1 iff err=0 and exactly IMG_WIDTH*IMG_HEIGHT words were written.
  - Otherwise frame_err=1; this includes a short frame with fewer lines.
  - The two pulses are never both asserted.
- Simultaneous events:
  - href high while vsync high is ignored (no writes).
  - vsync rise coincident with a final second byte: that write completes before the frame-end evaluation.
- Width rules:
  - Pixel counter is $clog2(IMG_WIDTH+1) bits and saturates at IMG_WIDTH+1.
  - Total-count compare is done at ADDR_W+1 bits.

Decomposition:
- Shared package cam_pkg: IMG_WIDTH/IMG_HEIGHT defaults, FRAME_PIXELS constant, ADDR_W, and the FSM state enum (IDLE, ARMED, CAPTURE). The VGA scan-out reuses the same dimensions.
- One natural sub-module, cam_byte_pair: input register stage, byte-phase toggle and RGB565 word formation. The top keeps the FSM, address counter and error checks.

Test Plan:
- Full frame: enable=1, vsync pulse, then 240 lines of 640 bytes with data = byte index mod 256 -> 76800 wr_en pulses. First wr_data=16'h0001 at wr_addr=0; last wr_addr=76799. frame_done pulses once after vsync rises; frame_err=0.
- Short line: line 10 carries 638 bytes -> 319 writes on that line. frame_err=1 and frame_done=0 at frame end; the next clean frame gives frame_done.
- Overlong frame: 241 full lines -> wr_en never asserts beyond wr_addr=76799; frame_err=1.
- Mid-frame start: enable raised during line 100 of an active frame -> no wr_en until after the next vsync high->low; the following frame gives frame_done.
- Reset at wr_addr=5000 -> all outputs 0 next cycle, no pulses. With enable=1, the next vsync cycle gives a normal full capture starting at wr_addr=0.
- enable dropped at line 50 -> frame completes with frame_done, FSM goes to IDLE. The subsequent frame produces no writes; busy=0.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared camera / frame-buffer definitions. The VGA scan-out imports the
// same dimensions so both sides agree on the 320x240 RGB565 buffer layout.
package cam_pkg;

    // Number of words in one frame for a given geometry.
    function automatic int frame_pixels(input int width, input int height);
        return width * height;
    endfunction

    localparam int DEF_IMG_WIDTH    = 320;
    localparam int DEF_IMG_HEIGHT   = 240;
    localparam int DEF_FRAME_PIXELS = frame_pixels(DEF_IMG_WIDTH, DEF_IMG_HEIGHT);
    // Wide enough for DEF_FRAME_PIXELS-1 = 76799.
    localparam int DEF_ADDR_W       = 17;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } cam_state_e;

endpackage

// File: rtl/cam_byte_pair.sv
// Sensor-side front end: registers the DVP inputs once, keeps a delayed
// vsync/href copy for edge detection, and pairs bytes into RGB565 words.
module cam_byte_pair (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  d,
    input  logic        capture,
    input  logic        phase_clr,
    output logic        vsync_s1,
    output logic        vsync_rise,
    output logic        vsync_fall,
    output logic        href_fall,
    output logic        phase,
    output logic        word_vld,
    output logic [15:0] word
);

    logic       vsync_s1_q, vsync_s1_d;
    logic       href_s1_q, href_s1_d;
    logic [7:0] d_s1_q, d_s1_d;
    logic       vsync_s2_q, vsync_s2_d;
    logic       href_s2_q, href_s2_d;
    logic       phase_q, phase_d;
    logic [7:0] hi_q, hi_d;
    logic       byte_take;

    // A byte is consumed only while the top is capturing and the line is active.
    assign byte_take = capture && href_s1_q;

    // Next-state for the input stage, byte phase and held high byte.
    always_comb begin
        // NOTE: every signal gets its default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        vsync_s1_d = vsync;
        href_s1_d  = href;
        d_s1_d     = d;
        vsync_s2_d = vsync_s1_q;
        href_s2_d  = href_s1_q;
        phase_d    = phase_q;
        hi_d       = hi_q;

        // A dangling high byte at line end is simply dropped by the clear.
        if (phase_clr || href_fall) begin
            phase_d = 1'b0;
        end else if (byte_take) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                hi_d = d_s1_q;
            end
        end
    end

    // Input registers and pairing state, synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            vsync_s1_q <= 1'b0;
            href_s1_q  <= 1'b0;
            d_s1_q     <= '0;
            vsync_s2_q <= 1'b0;
            href_s2_q  <= 1'b0;
            phase_q    <= 1'b0;
            hi_q       <= '0;
        end else begin
            vsync_s1_q <= vsync_s1_d;
            href_s1_q  <= href_s1_d;
            d_s1_q     <= d_s1_d;
            vsync_s2_q <= vsync_s2_d;
            href_s2_q  <= href_s2_d;
            phase_q    <= phase_d;
            hi_q       <= hi_d;
        end
    end

    assign vsync_s1   = vsync_s1_q;
    assign vsync_rise = vsync_s1_q && !vsync_s2_q;
    assign vsync_fall = !vsync_s1_q && vsync_s2_q;
    assign href_fall  = !href_s1_q && href_s2_q;
    assign phase      = phase_q;
    assign word_vld   = byte_take && phase_q;
    assign word       = {hi_q, d_s1_q};

endmodule

// File: rtl/cam_capture_565.sv
// Camera capture stage: frames the paired RGB565 words into the row-major
// frame buffer (addr = y*IMG_WIDTH + x) and reports clean or broken frames.
module cam_capture_565
    import cam_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic              PCLK,
    input  logic              reset,
    input  logic              enable,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              wr_en,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy
);

    localparam int FRAME_PIXELS = frame_pixels(IMG_WIDTH, IMG_HEIGHT);
    localparam int PIX_W        = $clog2(IMG_WIDTH + 1);

    localparam logic [PIX_W-1:0]  PIX_FULL  = PIX_W'(IMG_WIDTH);
    localparam logic [PIX_W-1:0]  PIX_SAT   = PIX_W'(IMG_WIDTH + 1);
    // One extra bit so a full frame count never aliases to zero.
    localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(FRAME_PIXELS);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_PIXELS - 1);

    cam_state_e        state_q, state_d;
    logic              capture;
    logic              arm_clr;
    logic              frame_ok;

    logic              vsync_s1, vsync_rise, vsync_fall, href_fall;
    logic              phase, word_vld;
    logic [15:0]       word;

    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
    logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic              err_q, err_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;

    assign capture = (state_q == CAPTURE);
    // Frame start: armed, still enabled, and vsync just left blanking.
    assign arm_clr = (state_q == ARMED) && enable && vsync_fall;

    cam_byte_pair u_byte_pair (
        .clk        (PCLK),
        .reset      (reset),
        .vsync      (vsync),
        .href       (href),
        .d          (d),
        .capture    (capture),
        .phase_clr  (arm_clr),
        .vsync_s1   (vsync_s1),
        .vsync_rise (vsync_rise),
        .vsync_fall (vsync_fall),
        .href_fall  (href_fall),
        .phase      (phase),
        .word_vld   (word_vld),
        .word       (word)
    );

    // Write port, address/word counters and framing-error accumulation.
    always_comb begin
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        wr_cnt_d  = wr_cnt_q;
        pix_cnt_d = pix_cnt_q;
        err_d     = err_q;

        if (arm_clr) begin
            wr_addr_d = '0;
            wr_cnt_d  = '0;
            pix_cnt_d = '0;
            err_d     = 1'b0;
        end else begin
            // Address moves on the cycle after the strobe; it parks on the
            // last location rather than wrapping.
            if (wr_en_q && (wr_addr_q != ADDR_LAST)) begin
                wr_addr_d = wr_addr_q + 1'b1;
            end

            if (word_vld) begin
                if (pix_cnt_q != PIX_SAT) begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                end
                if (wr_cnt_q < CNT_FULL) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = word;
                    wr_cnt_d  = wr_cnt_q + 1'b1;
                end else begin
                    // Frame overflow: drop the word and flag the frame.
                    err_d = 1'b1;
                end
            end

            if (capture && href_fall) begin
                if ((pix_cnt_q != PIX_FULL) || phase) begin
                    err_d = 1'b1;
                end
                pix_cnt_d = '0;
            end
        end

        // Evaluated on next-state values so a word landing on the vsync
        // rise cycle is already counted.
        frame_ok = !err_d && (wr_cnt_d == CNT_FULL);
    end

    // Frame FSM next state and end-of-frame pulses.
    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && vsync_s1) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (vsync_fall) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // enable is only looked at here; a running frame always completes.
                if (vsync_rise) begin
                    frame_done_d = frame_ok;
                    frame_err_d  = !frame_ok;
                    state_d      = enable ? ARMED : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, synchronous active-high reset.
    always_ff @(posedge PCLK) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_cnt_q     <= '0;
            pix_cnt_q    <= '0;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            wr_cnt_q     <= wr_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_en      = wr_en_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign busy       = capture;

endmodule
